seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_pkg.sv | 52 +++++
 rtl/seg7_decode.sv | 14 +
 rtl/seg_scan_ctrl.sv | 115 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scan controller.
package seg_scan_pkg;

    // Anode pattern that selects digit 0, and the "no digit selected" pattern
    localparam logic [3:0] ANODE_RESET = 4'b1110;
    localparam logic [3:0] ALL_OFF_AN  = 4'b1111;

    // All segments dark (active-low)
    localparam logic [6:0] SEG_BLANK   = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n drives hex digit n
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // One stored digit: [4] decimal point on, [3:0] hex nibble
    typedef logic [4:0] digit_t;

    // Next anode pattern of the scan ring (rotate right)
    function automatic logic [3:0] ring_rotate(input logic [3:0] ring);
        return {ring[0], ring[3:1]};
    endfunction

    // Digit index selected by a ring pattern; scan order is 0,3,2,1
    function automatic logic [1:0] ring_to_idx(input logic [3:0] ring);
        logic [1:0] idx;
        case (ring)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    // Table lookup of the segment pattern for the nibble
    always_comb begin
        o_seg = SEG_TABLE[i_hex];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with shadow/display
// double buffering committed at frame wrap, and per-slot anode dead time.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [3:0] digit_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] slot_idx,
    output logic       frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_ring;
    logic [3:0]       w_ring_nxt;
    logic [1:0]       r_slot;
    logic [1:0]       w_slot_nxt;
    digit_t [3:0]     r_shadow;
    digit_t [3:0]     w_shadow_nxt;
    digit_t [3:0]     r_disp;
    digit_t [3:0]     w_disp_nxt;
    logic             w_adv;
    logic             w_wrap;
    logic             w_lit;
    digit_t           w_cur;
    logic [6:0]       w_seg;

    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_done;

    // Prescale counter and slot ring next-state; the slot steps after terminal count
    always_comb begin
        w_adv      = (r_cnt == CNT_LAST);
        w_cnt_nxt  = w_adv ? '0 : r_cnt + CNT_W'(1);
        w_ring_nxt = w_adv ? ring_rotate(r_ring) : r_ring;
        w_slot_nxt = ring_to_idx(w_ring_nxt);
        w_wrap     = w_adv && (r_slot == 2'd1);
    end

    // Shadow write merge, and frame-wrap commit of the merged shadow so a
    // write landing on the commit edge is part of the new frame
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (wr_en) begin
            w_shadow_nxt[wr_addr] = wr_data;
        end
        w_disp_nxt = w_wrap ? w_shadow_nxt : r_disp;
    end

    // Output terms are formed from next-state values so the registered
    // outputs line up with the counter/slot state they describe
    always_comb begin
        w_cur = w_disp_nxt[w_slot_nxt];
        w_lit = digit_en[w_slot_nxt] && (int'(w_cnt_nxt) >= BLANK_CYCLES);
    end

    seg7_decode u_seg7_decode (
        .i_hex (w_cur[3:0]),
        .o_seg (w_seg)
    );

    // Scan state, shadow and display registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_ring   <= ANODE_RESET;
            r_slot   <= 2'd0;
            r_shadow <= '0;
            r_disp   <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_ring   <= w_ring_nxt;
            r_slot   <= w_slot_nxt;
            r_shadow <= w_shadow_nxt;
            r_disp   <= w_disp_nxt;
        end
    end

    // Registered display outputs and frame-wrap pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_an         <= ALL_OFF_AN;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_lit ? w_ring_nxt : ALL_OFF_AN;
            r_seg        <= w_seg;
            r_dp         <= ~w_cur[4];
            r_frame_done <= w_wrap;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign slot_idx   = r_slot;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (PRESCALE=8, BLANK_CYCLES=2),
// plus a PRESCALE=1/BLANK_CYCLES=0 instance for the fastest scan rate.
module tb_seg_scan_ctrl;

    localparam int P = 8;
    localparam int B = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [4:0] wr_data = 5'd0;
    logic [3:0] digit_en = 4'hF;

    logic [3:0] an, an1;
    logic [6:0] seg, seg1;
    logic       dp, dp1;
    logic [1:0] slot_idx, slot_idx1;
    logic       frame_done, frame_done1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Slot k of a frame: anode pattern and digit index (scan order 0,3,2,1)
    logic [3:0] RINGS [4] = '{4'b1110, 4'b0111, 4'b1011, 4'b1101};
    int         IDX   [4] = '{0, 3, 2, 1};

    always #5 clock = ~clock;

    seg_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .digit_en   (digit_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .slot_idx   (slot_idx),
        .frame_done (frame_done)
    );

    seg_scan_ctrl #(.PRESCALE(1), .BLANK_CYCLES(0)) dut_fast (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .digit_en   (digit_en),
        .an         (an1),
        .seg        (seg1),
        .dp         (dp1),
        .slot_idx   (slot_idx1),
        .frame_done (frame_done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    // Advance to the given position within the 32-cycle frame (bounded)
    task automatic run_to(input int pos);
        for (int i = 0; i < 32 && (cyc % 32) != pos; i++) step();
    endtask

    function automatic logic [3:0] exp_an(input int pos, input logic [3:0] en);
        int k;
        int c;
        k = pos / 8;
        c = pos % 8;
        return (c >= B && en[IDX[k]]) ? RINGS[k] : 4'hF;
    endfunction

    // One full frame from reset release: anode timing, slot index, no early pulse
    task automatic check_frame(input bit fast);
        for (int c = 0; c < 32; c++) begin
            check("an_scan", an, exp_an(c, 4'hF));
            check("slot_idx", slot_idx, IDX[c / 8]);
            check("fd_low", frame_done, 1'b0);
            if (fast && c >= 1) begin
                check("fast_an", an1, RINGS[c % 4]);
                check("fast_fd", frame_done1, (c % 4) == 0);
            end
            step();
        end
    endtask

    initial begin
        int waited;
        int pulses;

        repeat (3) @(negedge clock);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        check("rst_slot", slot_idx, 2'd0);
        reset = 1'b0;
        cyc = 0;

        check_frame(1'b1);
        check("wrap_fd", frame_done, 1'b1);
        check("wrap_seg0", seg, 7'b1000000);
        step();
        check("fd_width", frame_done, 1'b0);

        // Mid-frame writes stay hidden until the next commit
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 5'h08;
        step();
        wr_addr = 2'd3; wr_data = 5'h1F;
        step();
        wr_en = 1'b0;
        waited = 0;
        while (!frame_done && waited < 40) begin
            check("seg_hold", seg, 7'b1000000);
            step();
            waited++;
        end
        check("commit_wait", waited, 29);
        check("slot0_seg", seg, 7'b0000000);
        check("slot0_dp", dp, 1'b1);
        run_to(8);
        check("slot3_idx", slot_idx, 2'd3);
        check("slot3_seg", seg, 7'b0001110);
        check("slot3_dp", dp, 1'b0);

        // Write on the commit edge is included in the new frame
        run_to(31);
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 5'h05;
        step();
        wr_en = 1'b0;
        check("commit_fd", frame_done, 1'b1);
        run_to(16);
        check("slot2_idx", slot_idx, 2'd2);
        check("slot2_seg", seg, 7'b0010010);
        check("slot2_dp", dp, 1'b1);

        // Disable digit 2 for one frame
        run_to(31);
        digit_en = 4'b1011;
        step();
        for (int c = 0; c < 32; c++) begin
            check("an_digit_en", an, exp_an(c, 4'b1011));
            if (c == 16) check("seg_while_off", seg, 7'b0010010);
            if (c == 31) digit_en = 4'hF;
            step();
        end
        run_to(18);
        check("an_en_restored", an, 4'b1011);

        // Reset at count 5 of slot 3 with a pending shadow write
        run_to(12);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 5'h03;
        step();
        wr_en = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_slot", slot_idx, 2'd0);
        for (int i = 0; i < 3; i++) begin
            check("midrst_fd", frame_done, 1'b0);
            step();
        end
        reset = 1'b0;
        cyc = 0;
        check_frame(1'b0);
        check("restart_fd", frame_done, 1'b1);
        check("restart_seg0", seg, 7'b1000000);

        // Three frames of pulse spacing; pending write must have been dropped
        pulses = 0;
        step();
        while (cyc <= 128) begin
            check("fd_period", frame_done, (cyc % 32) == 0);
            if (frame_done) pulses++;
            if ((cyc % 32) == 24) check("slot1_discarded", seg, 7'b1000000);
            step();
        end
        check("pulse_count", pulses, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
